// File: rtl/noc_route_compute_pipe.sv
// Per-VC route-compute stage: decodes the head destination, holds the chosen output port for the
// packet and forwards each flit through a 1-cycle registered slice with framing/length/route error pulses.
module noc_route_compute_pipe #(
  parameter int         NUM_VC        = 4,
  parameter int         DATA_W        = 128,
  parameter int         ID_X_W        = 4,
  parameter int         ID_Y_W        = 4,
  parameter int         DEST_LSB      = 96,
  parameter int         ROUTE_MODE    = 0,
  parameter logic [4:0] ACTIVATE_PORT = 5'b11111,
  parameter int         MAX_PKT_LEN   = 16
) (
  input  logic                       noc_clk,
  input  logic                       noc_rst_n,
  input  logic [ID_X_W-1:0]          id_x,
  input  logic [ID_Y_W-1:0]          id_y,
  input  logic [3:0]                 congestion,
  input  logic [NUM_VC-1:0]          in_valid,
  output logic [NUM_VC-1:0]          in_ready,
  input  logic [NUM_VC*DATA_W-1:0]   in_flit,
  input  logic [NUM_VC-1:0]          in_head,
  input  logic [NUM_VC-1:0]          in_tail,
  output logic [NUM_VC-1:0]          out_valid,
  input  logic [NUM_VC-1:0]          out_ready,
  output logic [NUM_VC*DATA_W-1:0]   out_flit,
  output logic [NUM_VC-1:0]          out_head,
  output logic [NUM_VC-1:0]          out_tail,
  output logic [NUM_VC*5-1:0]        out_route,
  output logic [NUM_VC-1:0]          err_frame,
  output logic [NUM_VC-1:0]          err_len,
  output logic [NUM_VC-1:0]          err_unroute,
  output logic [15:0]                err_count
);
  localparam int LEN_W = $clog2(MAX_PKT_LEN + 2);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_PKT_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam int P_E = 0, P_W = 1, P_S = 2, P_N = 3, P_L = 4;

  typedef enum logic {S_IDLE, S_BODY} vc_state_t;

  function automatic logic [4:0] route_fn(input logic [ID_X_W-1:0] dest_x, input logic [ID_Y_W-1:0] dest_y,
                                          input logic [ID_X_W-1:0] cur_x, input logic [ID_Y_W-1:0] cur_y,
                                          input logic [3:0] cong);
    logic [4:0] port;
    logic [2:0] prod;
    port = 5'b0;
    prod = {dest_y < cur_y, dest_y > cur_y, dest_x > cur_x};  // productive N,S,E
    if (ROUTE_MODE == 1) begin
      if (dest_y > cur_y)      port[P_S] = 1'b1;
      else if (dest_y < cur_y) port[P_N] = 1'b1;
      else if (dest_x > cur_x) port[P_E] = 1'b1;
      else if (dest_x < cur_x) port[P_W] = 1'b1;
      else                     port[P_L] = 1'b1;
    end else if (ROUTE_MODE == 2) begin
      if (dest_x < cur_x)            port[P_W] = 1'b1;
      else if (prod == 3'b000)       port[P_L] = 1'b1;
      else if (prod[0] && !cong[0])  port[P_E] = 1'b1;
      else if (prod[1] && !cong[2])  port[P_S] = 1'b1;
      else if (prod[2] && !cong[3])  port[P_N] = 1'b1;
      else if (prod[0])              port[P_E] = 1'b1;
      else if (prod[1])              port[P_S] = 1'b1;
      else                           port[P_N] = 1'b1;
    end else begin
      if (dest_x > cur_x)      port[P_E] = 1'b1;
      else if (dest_x < cur_x) port[P_W] = 1'b1;
      else if (dest_y > cur_y) port[P_S] = 1'b1;
      else if (dest_y < cur_y) port[P_N] = 1'b1;
      else                     port[P_L] = 1'b1;
    end
    return port;
  endfunction

  logic w_unused;
  assign w_unused = ^congestion;

  logic [NUM_VC-1:0] w_ef_next, w_el_next, w_eu_next;

  genvar gi;
  for (gi = 0; gi < NUM_VC; gi++) begin : g_vc
    logic [DATA_W-1:0] w_flit;
    logic [ID_X_W-1:0] w_dest_x;
    logic [ID_Y_W-1:0] w_dest_y;
    logic              w_acc, w_fwd;
    logic [4:0]        w_new_route, w_out_route, w_route_next;
    logic [LEN_W-1:0]  w_len_next;
    vc_state_t         w_state_next;

    vc_state_t         r_state;
    logic [4:0]        r_route, r_out_route;
    logic [LEN_W-1:0]  r_len;
    logic              r_valid, r_head, r_tail, r_ef, r_el, r_eu;
    logic [DATA_W-1:0] r_flit;

    assign w_flit      = in_flit[gi*DATA_W +: DATA_W];
    assign w_dest_y    = w_flit[DEST_LSB +: ID_Y_W];
    assign w_dest_x    = w_flit[DEST_LSB+ID_Y_W +: ID_X_W];
    assign in_ready[gi] = !r_valid | out_ready[gi];
    assign w_acc       = in_valid[gi] & in_ready[gi];
    assign w_new_route = route_fn(w_dest_x, w_dest_y, id_x, id_y, congestion) & ACTIVATE_PORT;

    always_comb begin
      w_state_next   = r_state;
      w_route_next   = r_route;
      w_len_next     = r_len;
      w_fwd          = 1'b0;
      w_out_route    = r_route;
      w_ef_next[gi]  = 1'b0;
      w_el_next[gi]  = 1'b0;
      w_eu_next[gi]  = 1'b0;
      if (w_acc) begin
        if (in_head[gi]) begin
          // A head always starts a fresh packet, even if it interrupts one in progress.
          w_fwd         = 1'b1;
          w_out_route   = w_new_route;
          w_route_next  = w_new_route;
          w_eu_next[gi] = (w_new_route == 5'b0);
          w_ef_next[gi] = (r_state == S_BODY);
          w_state_next  = in_tail[gi] ? S_IDLE : S_BODY;
          w_len_next    = in_tail[gi] ? '0 : LEN_ONE;
        end else if (r_state == S_BODY) begin
          w_fwd = 1'b1;
          if (in_tail[gi]) begin
            w_state_next = S_IDLE;
            w_len_next   = '0;
          end else begin
            // Saturating at the limit makes the overrun pulse fire only once per packet.
            if (r_len < LEN_MAX) w_len_next = r_len + LEN_ONE;
            w_el_next[gi] = (r_len + LEN_ONE == LEN_MAX);
          end
        end else begin
          w_ef_next[gi] = 1'b1;
        end
      end
    end

    always_ff @(posedge noc_clk) begin
      if (!noc_rst_n) begin
        r_state     <= S_IDLE;
        r_route     <= '0;
        r_len       <= '0;
        r_valid     <= 1'b0;
        r_flit      <= '0;
        r_head      <= 1'b0;
        r_tail      <= 1'b0;
        r_out_route <= '0;
        r_ef        <= 1'b0;
        r_el        <= 1'b0;
        r_eu        <= 1'b0;
      end else begin
        r_state <= w_state_next;
        r_route <= w_route_next;
        r_len   <= w_len_next;
        r_ef    <= w_ef_next[gi];
        r_el    <= w_el_next[gi];
        r_eu    <= w_eu_next[gi];
        if (in_ready[gi]) begin
          r_valid <= w_fwd;
          if (w_fwd) begin
            r_flit      <= w_flit;
            r_head      <= in_head[gi];
            r_tail      <= in_tail[gi];
            r_out_route <= w_out_route;
          end
        end
      end
    end

    assign out_valid[gi]                = r_valid;
    assign out_flit[gi*DATA_W +: DATA_W] = r_flit;
    assign out_head[gi]                 = r_head;
    assign out_tail[gi]                 = r_tail;
    assign out_route[gi*5 +: 5]         = r_out_route;
    assign err_frame[gi]                = r_ef;
    assign err_len[gi]                  = r_el;
    assign err_unroute[gi]              = r_eu;
  end

  logic [7:0]  w_err_inc;
  logic [16:0] w_err_sum;
  logic [15:0] r_err_count;

  always_comb begin
    w_err_inc = '0;
    for (int i = 0; i < NUM_VC; i++)
      w_err_inc = w_err_inc + 8'(w_ef_next[i]) + 8'(w_el_next[i]) + 8'(w_eu_next[i]);
    w_err_sum = {1'b0, r_err_count} + 17'(w_err_inc);
  end

  always_ff @(posedge noc_clk) begin
    if (!noc_rst_n) r_err_count <= '0;
    else            r_err_count <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
  end

  assign err_count = r_err_count;
endmodule
